// File: rtl/nn_ctrl_if.sv
// nn_ctrl_if: control bundle between the nn_ctrl sequencer and the
// two-layer inference datapath.
//   master : the sequencer. It receives go/abort and the MAC done strobes.
//            It drives the SRAM addresses, MAC start strobes, hidden select
//            and the status flags.
//   slave  : the datapath/host side of the same wires.
// Signals:
//   go, abort, mac1_done, mac2_done  - requests/strobes into the sequencer
//   we, address_1/2/3/5              - SRAM control (we and address_5 tied 0)
//   sel                              - hidden-layer mux select
//   mac1_start, mac2_start           - MAC operand-valid strobes
//   busy, done, error                - status
interface nn_ctrl_if;
  logic        go;
  logic        abort;
  logic        mac1_done;
  logic        mac2_done;
  logic        we;
  logic [17:0] address_1;
  logic [11:0] address_2;
  logic [9:0]  address_3;
  logic [6:0]  address_5;
  logic [6:0]  sel;
  logic        mac1_start;
  logic        mac2_start;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  go, abort, mac1_done, mac2_done,
    output we, address_1, address_2, address_3, address_5, sel,
           mac1_start, mac2_start, busy, done, error
  );

  modport slave (
    output go, abort, mac1_done, mac2_done,
    input  we, address_1, address_2, address_3, address_5, sel,
           mac1_start, mac2_start, busy, done, error
  );
endinterface

// File: rtl/nn_ctrl.sv
// nn_ctrl: sequencing controller for the two-layer inference datapath.
// A go pulse in IDLE starts one pass, which runs these steps in order:
//   - stream N_IN layer-1 addresses;
//   - wait for mac1_done;
//   - stream N_HID*N_OUT layer-2 addresses;
//   - wait for mac2_done;
//   - pulse done.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all state and outputs
//   bus   - nn_ctrl_if.master
//           inputs:  go, abort, mac1_done, mac2_done
//           outputs: addresses, sel, mac*_start, busy, done, error
module nn_ctrl #(
  parameter int N_IN    = 784,
  parameter int N_HID   = 10,
  parameter int N_OUT   = 10,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  nn_ctrl_if.master   bus
);

  localparam int N_K    = N_HID * N_OUT;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // Refuse to elaborate parameter sets that would overflow the address ports.
  // The same applies to sets that would overflow the select port.
  generate
    if (N_IN < 1 || N_IN > 1024 || N_HID < 1 || N_HID > 128 ||
        N_OUT < 1 || N_K > 4096 || TIMEOUT < 1) begin : g_bad_params
      $error("nn_ctrl: parameter set exceeds the port ranges");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, L1_ISSUE, L1_WAIT, L2_ISSUE, L2_WAIT, FINISH
  } state_t;

  state_t             state, next_state;
  logic [9:0]         i_cnt;
  logic [11:0]        k_cnt;
  logic [11:0]        o_cnt;
  logic [6:0]         h_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               error_q;
  logic               mac1_start_q;
  logic               mac2_start_q;
  logic [6:0]         sel_q;
  logic               timeout;
  logic               flush;
  logic               last_i;
  logic               last_k;
  logic               last_o;
  logic               wait_expired;

  assign last_i       = (i_cnt == 10'(N_IN - 1));
  assign last_k       = (k_cnt == 12'(N_K - 1));
  assign last_o       = (o_cnt == 12'(N_OUT - 1));
  // The wait counter is cleared on entry, so the value TIMEOUT-1 marks
  // the last edge at which a done strobe is still accepted.
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  // flush marks every edge that returns the machine to IDLE. That covers
  // finish, timeout and abort. Registered strobes must not trail past it.
  assign flush        = (state != IDLE) && (next_state == IDLE);

  // Next-state logic. A done strobe takes priority over a timeout on the
  // same edge. Abort overrides everything outside IDLE.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      IDLE:     if (bus.go) next_state = L1_ISSUE;
      L1_ISSUE: if (last_i) next_state = L1_WAIT;
      L1_WAIT: begin
        if (bus.mac1_done) next_state = L2_ISSUE;
        else if (wait_expired) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      L2_ISSUE: if (last_k) next_state = L2_WAIT;
      L2_WAIT: begin
        if (bus.mac2_done) next_state = FINISH;
        else if (wait_expired) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      next_state = IDLE;
      timeout    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Address and wait counters. Every return to IDLE zeroes them, so the
  // addresses read 0 while idle and a new pass always starts from 0.
  // The layer-2 counter k runs alongside an (h, o) pair, so sel never
  // needs a divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_cnt    <= '0;
      k_cnt    <= '0;
      o_cnt    <= '0;
      h_cnt    <= '0;
      wait_cnt <= '0;
    end else if (next_state == IDLE) begin
      i_cnt    <= '0;
      k_cnt    <= '0;
      o_cnt    <= '0;
      h_cnt    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == L1_WAIT || state == L2_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                                      wait_cnt <= '0;
      if (state == L1_ISSUE && !last_i) i_cnt <= i_cnt + 10'd1;
      if (state == L2_ISSUE && !last_k) begin
        k_cnt <= k_cnt + 12'd1;
        if (last_o) begin
          o_cnt <= '0;
          h_cnt <= h_cnt + 7'd1;
        end else begin
          o_cnt <= o_cnt + 12'd1;
        end
      end
    end
  end

  // The SRAMs return data one cycle after the address, so the start
  // strobes and sel are delayed by one register. They clear on the same
  // edge that leaves for IDLE, so no trailing strobe is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac1_start_q <= 1'b0;
      mac2_start_q <= 1'b0;
      sel_q        <= '0;
    end else begin
      mac1_start_q <= (state == L1_ISSUE) && !flush;
      mac2_start_q <= (state == L2_ISSUE) && !flush;
      sel_q        <= flush ? 7'd0 : h_cnt;
    end
  end

  // Sticky timeout flag. Only a fresh go clears it; abort leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      error_q <= 1'b0;
    else if (state == IDLE && bus.go) error_q <= 1'b0;
    else if (timeout)               error_q <= 1'b1;
  end

  assign bus.we         = 1'b0;
  assign bus.address_5  = 7'd0;
  assign bus.address_1  = {8'd0, i_cnt};
  assign bus.address_3  = i_cnt;
  assign bus.address_2  = k_cnt;
  assign bus.sel        = sel_q;
  assign bus.mac1_start = mac1_start_q;
  assign bus.mac2_start = mac2_start_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FINISH);
  assign bus.error      = error_q;

endmodule
